// File: rtl/i2c_txn_sequencer.sv
// I2C transaction sequencer: turns a {addr, wr_len, rd_len} descriptor into engine txfifo
// packets (START/address, payload, read slots, STOP) and streams read bytes back from the rxfifo.
module i2c_txn_sequencer #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_addr,
    input  logic [LEN_W-1:0] req_wr_len,
    input  logic [LEN_W-1:0] req_rd_len,

    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [7:0]       wd_data,

    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,

    output logic             busy,
    output logic             done,

    output logic             eng_wr_stb,
    output logic             eng_restart,
    output logic             eng_stop,
    output logic             eng_cdm,
    output logic [7:0]       eng_din,
    input  logic             eng_tx_full,

    output logic             eng_rd_stb,
    input  logic [7:0]       eng_dout,
    input  logic             eng_rx_empty
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_W,
        WDATA,
        ADDR_R,
        RSLOT,
        DRAIN
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state, state_nxt;
    logic [6:0]       addr_q;
    logic [LEN_W-1:0] wr_len_q, rd_len_q;
    logic [LEN_W-1:0] wr_cnt, slot_cnt, rd_cnt;
    logic             accept, probe, last_wr, last_slot, drain_exit;

    assign accept    = req_valid && req_ready;
    assign probe     = (wr_len_q == '0) && (rd_len_q == '0);
    assign last_wr   = (wr_cnt == LEN_ONE);
    assign last_slot = (slot_cnt == LEN_ONE);
    assign busy      = (state != IDLE);

    // The read-return path runs independently of the push states; it only pops bytes it asked for.
    assign eng_rd_stb = !eng_rx_empty && (rd_cnt != '0) && (!rd_valid || rd_ready);

    // NOTE: every output of this block is given a default first so no path leaves one unassigned,
    // which is what keeps synthesis from inferring latches.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        wd_ready    = 1'b0;
        eng_wr_stb  = 1'b0;
        eng_restart = 1'b0;
        eng_stop    = 1'b0;
        eng_cdm     = 1'b0;
        eng_din     = 8'h00;
        drain_exit  = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ((req_wr_len != '0) || (req_rd_len == '0)) ? ADDR_W : ADDR_R;
                end
            end
            ADDR_W: begin
                if (!eng_tx_full) begin
                    eng_wr_stb  = 1'b1;
                    eng_din     = {addr_q, 1'b0};
                    eng_cdm     = 1'b1;
                    eng_restart = 1'b1;
                    eng_stop    = probe;
                    state_nxt   = probe ? DRAIN : WDATA;
                end
            end
            WDATA: begin
                wd_ready = !eng_tx_full;
                if (wd_valid && !eng_tx_full) begin
                    eng_wr_stb = 1'b1;
                    eng_din    = wd_data;
                    eng_stop   = last_wr && (rd_len_q == '0);
                    if (last_wr) begin
                        state_nxt = (rd_len_q != '0) ? ADDR_R : DRAIN;
                    end
                end
            end
            ADDR_R: begin
                if (!eng_tx_full) begin
                    eng_wr_stb  = 1'b1;
                    eng_din     = {addr_q, 1'b1};
                    eng_cdm     = 1'b1;
                    eng_restart = 1'b1;
                    state_nxt   = RSLOT;
                end
            end
            RSLOT: begin
                if (!eng_tx_full) begin
                    eng_wr_stb = 1'b1;
                    eng_din    = 8'hFF;
                    eng_stop   = last_slot;
                    if (last_slot) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((rd_cnt == '0) && (!rd_valid || rd_ready)) begin
                    drain_exit = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values,
    // regardless of statement order inside this block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wr_len_q <= '0;
            rd_len_q <= '0;
            wr_cnt   <= '0;
            slot_cnt <= '0;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= drain_exit;

            if (accept) begin
                addr_q   <= req_addr;
                wr_len_q <= req_wr_len;
                rd_len_q <= req_rd_len;
                wr_cnt   <= req_wr_len;
                slot_cnt <= req_rd_len;
            end else begin
                if ((state == WDATA) && eng_wr_stb) wr_cnt   <= wr_cnt - LEN_ONE;
                if ((state == RSLOT) && eng_wr_stb) slot_cnt <= slot_cnt - LEN_ONE;
            end

            // Accept only happens in IDLE, where the outstanding count is already zero.
            if (accept) begin
                rd_cnt <= req_rd_len;
            end else if (eng_rd_stb) begin
                rd_cnt <= rd_cnt - LEN_ONE;
            end

            if (eng_rd_stb) begin
                rd_data  <= eng_dout;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench for i2c_txn_sequencer: table of directed transactions with hand-computed
// packet streams, plus hand-written backpressure, unsolicited-rx and mid-transaction reset sequences.
module tb_i2c_txn_sequencer;

    localparam int LEN_W = 4;
    // Output vector order: req_ready, wd_ready, rd_valid, rd_data, busy, done,
    // eng_wr_stb, eng_restart, eng_stop, eng_cdm, eng_din, eng_rd_stb.
    localparam logic [25:0] RST_VAL = 26'h200_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [6:0]       req_addr;
    logic [LEN_W-1:0] req_wr_len, req_rd_len;
    logic             wd_valid, wd_ready;
    logic [7:0]       wd_data;
    logic             rd_valid, rd_ready;
    logic [7:0]       rd_data;
    logic             busy, done;
    logic             eng_wr_stb, eng_restart, eng_stop, eng_cdm;
    logic [7:0]       eng_din;
    logic             eng_tx_full;
    logic             eng_rd_stb;
    logic [7:0]       eng_dout;
    logic             eng_rx_empty;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr_len(req_wr_len), .req_rd_len(req_rd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .eng_wr_stb(eng_wr_stb), .eng_restart(eng_restart), .eng_stop(eng_stop),
        .eng_cdm(eng_cdm), .eng_din(eng_din), .eng_tx_full(eng_tx_full),
        .eng_rd_stb(eng_rd_stb), .eng_dout(eng_dout), .eng_rx_empty(eng_rx_empty)
    );

    // Packets are recorded as {restart, stop, cdm, din}.
    typedef struct packed {
        logic [6:0]        addr;
        logic [3:0]        wr_len;
        logic [3:0]        rd_len;
        logic [3:0][7:0]   wd;
        logic [3:0][7:0]   rx;
        logic [3:0]        n_push;
        logic [7:0][10:0]  push;
        logic [3:0]        busy;
    } vec_t;

    vec_t        vecs[6];
    logic [7:0]  wd_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  rd_q[$];
    logic [10:0] push_q[$];
    int errors, checks;
    int idle_viol, pop_viol, full_viol, full_cycles, rd_stall_cycles;
    int done_cnt, busy_cnt, rd_stb_cnt, full_left, rdlo_left, stops;
    bit acc_seen, arm_full, arm_rd, wd_take, rx_take;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [25:0] outs();
        return {req_ready, wd_ready, rd_valid, rd_data, busy, done, eng_wr_stb,
                eng_restart, eng_stop, eng_cdm, eng_din, eng_rd_stb};
    endfunction

    task automatic drive();
        wd_valid     = (wd_q.size() != 0);
        wd_data      = wd_valid ? wd_q[0] : 8'h00;
        eng_rx_empty = (rx_q.size() == 0);
        eng_dout     = eng_rx_empty ? 8'h00 : rx_q[0];
        eng_tx_full  = (full_left != 0);
        if (full_left != 0) full_left--;
        rd_ready     = (rdlo_left == 0);
        if (rdlo_left != 0) rdlo_left--;
    endtask

    // One clock: observe at the falling edge, update the engine/source/sink models after the rising edge.
    task automatic tick();
        @(negedge clk);
        wd_take = wd_valid && wd_ready;
        rx_take = eng_rd_stb;
        if (eng_wr_stb) push_q.push_back({eng_restart, eng_stop, eng_cdm, eng_din});
        else if ({eng_restart, eng_stop, eng_cdm, eng_din} != 11'd0) idle_viol++;
        if (rd_valid && rd_ready) rd_q.push_back(rd_data);
        if (eng_rd_stb) rd_stb_cnt++;
        if (eng_rd_stb && (eng_rx_empty || (rd_valid && !rd_ready))) pop_viol++;
        if (eng_tx_full && (eng_wr_stb || wd_ready)) full_viol++;
        if (eng_tx_full) full_cycles++;
        if (rd_valid && !rd_ready) rd_stall_cycles++;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (req_valid && req_ready) acc_seen = 1'b1;
        if (arm_full && wd_take) begin full_left = 5; arm_full = 1'b0; end
        if (arm_rd && rd_valid) begin rdlo_left = 3; arm_rd = 1'b0; end
        @(posedge clk);
        #1;
        if (wd_take) void'(wd_q.pop_front());
        if (rx_take) void'(rx_q.pop_front());
        drive();
    endtask

    task automatic prep_txn(input vec_t v, input bit preload_rx);
        idle_viol = 0; pop_viol = 0; full_viol = 0; full_cycles = 0; rd_stall_cycles = 0;
        done_cnt = 0; busy_cnt = 0; rd_stb_cnt = 0; acc_seen = 1'b0;
        push_q.delete();
        rd_q.delete();
        for (int k = 0; k < int'(v.wr_len); k++) wd_q.push_back(v.wd[k]);
        if (preload_rx) for (int k = 0; k < int'(v.rd_len); k++) rx_q.push_back(v.rx[k]);
        drive();
        req_addr   = v.addr;
        req_wr_len = v.wr_len;
        req_rd_len = v.rd_len;
        req_valid  = 1'b1;
    endtask

    task automatic start_txn(input vec_t v, input bit preload_rx);
        prep_txn(v, preload_rx);
        for (int n = 0; n < 20 && !acc_seen; n++) tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200 && done_cnt == 0; n++) tick();
        repeat (3) tick();
    endtask

    task automatic check_vec(input vec_t v, input string nm, input bit chk_busy);
        check($sformatf("%s push_count", nm), push_q.size(), 32'(v.n_push));
        for (int k = 0; k < int'(v.n_push); k++)
            check($sformatf("%s push%0d", nm, k),
                  (k < push_q.size()) ? 32'(push_q[k]) : 32'hDEAD_BEEF, 32'(v.push[k]));
        check($sformatf("%s rd_count", nm), rd_q.size(), 32'(v.rd_len));
        for (int k = 0; k < int'(v.rd_len); k++)
            check($sformatf("%s rd_byte%0d", nm, k),
                  (k < rd_q.size()) ? 32'(rd_q[k]) : 32'hDEAD_BEEF, 32'(v.rx[k]));
        check($sformatf("%s rd_pops", nm), rd_stb_cnt, 32'(v.rd_len));
        check($sformatf("%s done_pulses", nm), done_cnt, 1);
        check($sformatf("%s idle_fields", nm), idle_viol, 0);
        check($sformatf("%s pop_rule", nm), pop_viol, 0);
        check($sformatf("%s push_while_full", nm), full_viol, 0);
        if (chk_busy) check($sformatf("%s busy_cycles", nm), busy_cnt, 32'(v.busy));
    endtask

    initial begin
        errors = 0; checks = 0; full_left = 0; rdlo_left = 0;
        arm_full = 1'b0; arm_rd = 1'b0; wd_take = 1'b0; rx_take = 1'b0;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_wr_len = '0; req_rd_len = '0;
        drive();

        // Write-only 0x50, A5 3C
        vecs[0] = '0; vecs[0].addr = 7'h50; vecs[0].wr_len = 4'd2; vecs[0].rd_len = 4'd0;
        vecs[0].wd[0] = 8'hA5; vecs[0].wd[1] = 8'h3C;
        vecs[0].n_push = 4'd3; vecs[0].busy = 4'd4;
        vecs[0].push[0] = 11'h5A0; vecs[0].push[1] = 11'h0A5; vecs[0].push[2] = 11'h23C;
        // Combined 0x50: write 5A, read 11 22
        vecs[1] = '0; vecs[1].addr = 7'h50; vecs[1].wr_len = 4'd1; vecs[1].rd_len = 4'd2;
        vecs[1].wd[0] = 8'h5A; vecs[1].rx[0] = 8'h11; vecs[1].rx[1] = 8'h22;
        vecs[1].n_push = 4'd5; vecs[1].busy = 4'd6;
        vecs[1].push[0] = 11'h5A0; vecs[1].push[1] = 11'h05A; vecs[1].push[2] = 11'h5A1;
        vecs[1].push[3] = 11'h0FF; vecs[1].push[4] = 11'h2FF;
        // Address probe 0x3C
        vecs[2] = '0; vecs[2].addr = 7'h3C; vecs[2].n_push = 4'd1; vecs[2].busy = 4'd2;
        vecs[2].push[0] = 11'h778;
        // Read-only 0x21: 01 02 03
        vecs[3] = '0; vecs[3].addr = 7'h21; vecs[3].rd_len = 4'd3;
        vecs[3].rx[0] = 8'h01; vecs[3].rx[1] = 8'h02; vecs[3].rx[2] = 8'h03;
        vecs[3].n_push = 4'd4; vecs[3].busy = 4'd5;
        vecs[3].push[0] = 11'h543; vecs[3].push[1] = 11'h0FF; vecs[3].push[2] = 11'h0FF;
        vecs[3].push[3] = 11'h2FF;
        // Top address 0x7F: write 00 FF 80, read C3
        vecs[4] = '0; vecs[4].addr = 7'h7F; vecs[4].wr_len = 4'd3; vecs[4].rd_len = 4'd1;
        vecs[4].wd[0] = 8'h00; vecs[4].wd[1] = 8'hFF; vecs[4].wd[2] = 8'h80; vecs[4].rx[0] = 8'hC3;
        vecs[4].n_push = 4'd6; vecs[4].busy = 4'd7;
        vecs[4].push[0] = 11'h5FE; vecs[4].push[1] = 11'h000; vecs[4].push[2] = 11'h0FF;
        vecs[4].push[3] = 11'h080; vecs[4].push[4] = 11'h5FF; vecs[4].push[5] = 11'h2FF;
        // Backpressure 0x50: write 11 22 33, read AA BB CC
        vecs[5] = '0; vecs[5].addr = 7'h50; vecs[5].wr_len = 4'd3; vecs[5].rd_len = 4'd3;
        vecs[5].wd[0] = 8'h11; vecs[5].wd[1] = 8'h22; vecs[5].wd[2] = 8'h33;
        vecs[5].rx[0] = 8'hAA; vecs[5].rx[1] = 8'hBB; vecs[5].rx[2] = 8'hCC;
        vecs[5].n_push = 4'd8;
        vecs[5].push[0] = 11'h5A0; vecs[5].push[1] = 11'h011; vecs[5].push[2] = 11'h022;
        vecs[5].push[3] = 11'h033; vecs[5].push[4] = 11'h5A1; vecs[5].push[5] = 11'h0FF;
        vecs[5].push[6] = 11'h0FF; vecs[5].push[7] = 11'h2FF;

        repeat (2) @(negedge clk);
        check("reset_values", 32'(outs()), 32'(RST_VAL));
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            start_txn(vecs[i], 1'b1);
            wait_done();
            check_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Engine full for 5 cycles after the first write byte; sink stalls 3 cycles on first read.
        arm_full = 1'b1;
        arm_rd   = 1'b1;
        start_txn(vecs[5], 1'b1);
        wait_done();
        check_vec(vecs[5], "backpressure", 1'b0);
        check("bp full_cycles", full_cycles, 5);
        check("bp rd_stall_cycles", rd_stall_cycles, 3);

        // Stray bytes in the rxfifo during a write-only transaction must be left alone.
        rx_q.push_back(8'hEE);
        rx_q.push_back(8'hDD);
        start_txn(vecs[0], 1'b1);
        wait_done();
        check_vec(vecs[0], "unsolicited", 1'b1);
        check("unsolicited rx_left", rx_q.size(), 2);
        rx_q.delete();
        drive();

        // Reset while in RSLOT, then a request on the very first edge after release.
        vecs[3].rd_len = 4'd4;
        start_txn(vecs[3], 1'b0);
        for (int n = 0; n < 20 && push_q.size() < 2; n++) tick();
        #2 rst = 1'b0;
        #1 check("abort_async", 32'(outs()), 32'(RST_VAL));
        @(negedge clk);
        check("abort_hold", 32'(outs()), 32'(RST_VAL));
        stops = 0;
        foreach (push_q[k]) if (push_q[k][9]) stops++;
        check("abort_no_stop", stops, 0);
        check("abort_pushes", push_q.size(), 2);
        @(negedge clk);
        prep_txn(vecs[0], 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_accept", 32'(busy), 1);
        req_valid = 1'b0;
        wait_done();
        check_vec(vecs[0], "post_reset", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_txn_sequencer.md
I2C_TXN_SEQUENCER -- requirements
Module: i2c_txn_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 4; width of the write and read byte-count fields, giving at most 2^LEN_W-1 bytes per phase.
REQ-002 SHALL have clk input 1; the single clock. All logic is on its rising edge.
REQ-003 SHALL have rst input 1; asynchronous, active-low reset.
REQ-004 SHALL have req_valid in 1, req_ready out 1, req_addr in 7, req_wr_len in LEN_W, req_rd_len in LEN_W; the transaction descriptor handshake.
REQ-005 SHALL have wd_valid in 1, wd_ready out 1, wd_data in 8; the write-payload stream.
REQ-006 SHALL have rd_valid out 1, rd_ready in 1, rd_data out 8; the read-payload stream.
REQ-007 SHALL have busy out 1 and done out 1; done is a one-cycle completion pulse.
REQ-008 SHALL have eng_wr_stb out 1, eng_restart out 1, eng_stop out 1, eng_cdm out 1, eng_din out 8, eng_tx_full in 1; the engine txfifo push port.
REQ-009 SHALL have eng_rd_stb out 1, eng_dout in 8, eng_rx_empty in 1; the engine rxfifo pop port. The rxfifo is first-word-fall-through.

Function
REQ-010 SHALL drive the FSM through these states: IDLE, ADDR_W, WDATA, ADDR_R, RSLOT, DRAIN.
REQ-011 SHALL hold req_ready=1 only in IDLE; on req_valid&&req_ready, latch addr, wr_len and rd_len. Next state is ADDR_W if wr_len>0 or rd_len==0; otherwise ADDR_R.
REQ-012 SHALL assert eng_wr_stb only in a cycle with eng_tx_full=0; while eng_tx_full=1 the state and all counters hold.
REQ-013 ADDR_W SHALL push one packet: din={addr,1'b0}, cdm=1, restart=1. It SHALL set stop=1 only when wr_len==0 and rd_len==0 (address probe); a probe then goes to DRAIN.
REQ-014 WDATA SHALL pass payload through combinationally:
- wd_ready = (state==WDATA) && !eng_tx_full.
- eng_wr_stb = wd_valid && wd_ready; din = wd_data; cdm=0; restart=0.
- stop=1 on the last write byte when rd_len==0.
- Leave WDATA after wr_len accepted beats, to ADDR_R if rd_len>0, else DRAIN.
REQ-015 ADDR_R SHALL push din={addr,1'b1}, cdm=1, restart=1, stop=0. This is a repeated START after a write phase, or a plain START when wr_len==0.
REQ-016 RSLOT SHALL push rd_len read-slot packets (din=8'hFF, cdm=0, restart=0), with stop=1 on the last one, then go to DRAIN.
REQ-017 SHALL keep an outstanding-read counter, loaded with rd_len at request accept, which runs concurrently with the push states. Pop rule:
- eng_rd_stb = !eng_rx_empty && (counter>0) && (!rd_valid || rd_ready).
- On eng_rd_stb, register eng_dout into rd_data, set rd_valid, and decrement the counter.
- Read latency is 1 cycle from stb to rd_valid.
REQ-018 SHALL never pop the rxfifo when the counter is 0; unsolicited bytes stay in the engine.
REQ-019 rd_valid SHALL clear on rd_ready unless a new pop occurs in the same cycle. With rd_ready held high, sustained throughput is 1 byte/cycle.
REQ-020 DRAIN SHALL exit to IDLE when the counter==0 and (!rd_valid, or rd_valid&&rd_ready). On exit, pulse done for exactly one cycle.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 eng_restart, eng_stop, eng_cdm and eng_din SHALL be 0 whenever eng_wr_stb=0.
REQ-023 Counter width SHALL be LEN_W; the counters never wrap, because decrement occurs only when nonzero.

Reset
REQ-024 On rst low, the block SHALL asynchronously go to IDLE and clear all counters.
REQ-025 Reset values: req_ready=1 and every other output 0, including rd_data=0.
REQ-026 Reset mid-transaction SHALL abort with no STOP packet emitted; engine recovery is outside this block.
REQ-027 Deassertion of rst SHALL be synchronous to clk; the first request can be accepted on the first clk edge after deassertion.

Verification
REQ-028 Write-only: addr=0x50, wr_len=2, rd_len=0, data A5,3C, tx never full -> 3 pushes on consecutive cycles: {A0,cdm,restart}, {A5}, {3C,stop}; done 1 cycle after DRAIN entry.
REQ-029 Combined: addr=0x50, wr_len=1, rd_len=2; engine returns 11,22 -> pushes A0(restart), data, A1(restart), FF, FF(stop); rd_data 11 then 22; done after the second byte is consumed.
REQ-030 Probe: wr_len=0, rd_len=0, addr=0x3C -> single push {78, cdm, restart, stop}; busy for 2 cycles; done pulses once.
REQ-031 Backpressure: eng_tx_full high for 5 cycles mid-WDATA, with rd_ready low for 3 cycles during reads -> no pushes and wd_ready=0 while full; no pop while rd_valid&&!rd_ready; byte order preserved.
REQ-032 Unsolicited rx data: rx non-empty during a write-only transaction -> eng_rd_stb never asserts.
REQ-033 Reset in RSLOT: rst low for 1 cycle -> outputs return to reset values immediately; a following request completes normally.
